// File: rtl/sipo_frame_rx_pkg.sv
// Shared types and constants for the framed serial receiver.
package sipo_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } rx_state_t;

    localparam int DATA_W_DEFAULT = 8;
    localparam int CNT_W_DEFAULT  = $clog2(DATA_W_DEFAULT);

    localparam bit PAR_SENSE_EVEN = 1'b0;
    localparam bit PAR_SENSE_ODD  = 1'b1;

    function automatic int cnt_width(input int data_w);
        return $clog2(data_w);
    endfunction

endpackage

// File: rtl/sipo_frame_rx_if.sv
// Word output handshake: dout is held stable while dout_valid=1; a word moves
// on any rising edge where dout_valid=1 and dout_ready=1.
interface sipo_frame_rx_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start(0), DATA_W bits LSB first, optional parity, stop(1).
// Parity bit and par_err are built only when SIPO_PARITY_EN is defined.
module sipo_frame_rx
    import sipo_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = PAR_SENSE_EVEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sin,
    sipo_frame_rx_if.master       dbus,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  par_err,
    output logic                  overrun,
    output rx_state_t             state_dbg
);

    localparam int                CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_t          state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  shreg;
    logic               par_bad;
    logic               stop_edge;
    logic               frame_good;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (!sin) state_n = DATA;
`ifdef SIPO_PARITY_EN
            DATA: if (cnt == LAST_BIT) state_n = PAR;
            PAR:  state_n = STOP;
`else
            DATA: if (cnt == LAST_BIT) state_n = STOP;
`endif
            STOP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign stop_edge  = (state == STOP);
    assign frame_good = stop_edge && sin && !par_bad;
    assign busy       = (state != IDLE);
    assign state_dbg  = state;

    // A completed word is never held back: it either replaces an accepted
    // word, fills an empty slot, or is dropped with an overrun pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt             <= '0;
            shreg           <= '0;
            dbus.dout       <= '0;
            dbus.dout_valid <= 1'b0;
            frame_err       <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            frame_err <= stop_edge && !sin;
            overrun   <= 1'b0;
            if (state == IDLE) cnt <= '0;
            if (state == DATA) begin
                shreg <= {sin, shreg[DATA_W-1:1]};
                cnt   <= cnt + 1'b1;
            end
            if (frame_good) begin
                if (!dbus.dout_valid || dbus.dout_ready) begin
                    dbus.dout       <= shreg;
                    dbus.dout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dbus.dout_valid && dbus.dout_ready) begin
                dbus.dout_valid <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_EN
    // par_bad is latched at the parity edge and consumed at the stop edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad <= 1'b0;
            par_err <= 1'b0;
        end else begin
            par_err <= stop_edge && par_bad;
            if (state == PAR)       par_bad <= (sin != ((^shreg) ^ PARITY_ODD));
            else if (state == IDLE) par_bad <= 1'b0;
        end
    end
`else
    assign par_bad = 1'b0;
    assign par_err = 1'b0;
`endif

endmodule
